// File: rtl/lab1_imul_set_bit_scanner.sv
// lab1_imul_set_bit_scanner
// Multi-cycle set-bit scanner for the iterative multiplier. Accepts one
// operand over a val/rdy handshake and emits each set bit LSB first, one
// record per cycle, carrying the absolute position and the shift distance
// from the previously emitted set bit. A zero operand yields a single
// marker record with out_empty=1.
//
// Optional feature: define LAB1_IMUL_SET_BIT_SCANNER_OVERLAP_EN to accept
// the next operand on the same edge as the final record of the current
// one, removing the idle bubble between operands.

module lab1_imul_set_bit_scanner #(
  parameter  int unsigned p_nbits = 32,
  localparam int unsigned p_pbits = $clog2(p_nbits)
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,

  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_pbits-1:0] out_pos,
  output logic [p_pbits-1:0] out_delta,
  output logic               out_last,
  output logic               out_empty
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e               r_state;
  logic [p_nbits-1:0]   r_residue;
  logic [p_pbits-1:0]   r_prev_pos;
  logic                 r_zero_flag;

  state_e               w_state_nxt;
  logic [p_nbits-1:0]   w_residue_nxt;
  logic [p_pbits-1:0]   w_prev_pos_nxt;
  logic                 w_zero_flag_nxt;

  logic [p_pbits-1:0]   w_low_pos;
  logic                 w_found;
  logic [p_nbits-1:0]   w_residue_m1;
  logic [p_nbits-1:0]   w_residue_drop;
  logic                 w_last;
  logic                 w_in_rdy;
  logic                 w_out_val;
  logic                 w_in_go;
  logic                 w_out_go;

  // Priority encoder: index of the lowest set bit of the residue (0 if none).
  always_comb begin
    w_low_pos = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < p_nbits; i++) begin
      if (!w_found && r_residue[i]) begin
        w_low_pos = p_pbits'(i);
        w_found   = 1'b1;
      end
    end
  end

  // x & (x-1) drops the lowest set bit; a zero result means at most one bit was set.
  always_comb begin
    w_residue_m1   = r_residue - p_nbits'(1);
    w_residue_drop = r_residue & w_residue_m1;
    w_last         = (w_residue_drop == '0);
  end

  // Handshake qualifiers; both ready and valid are forced low during reset.
  always_comb begin
    w_out_val = 1'b0;
    w_in_rdy  = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: w_in_rdy = 1'b1;
        EMIT: begin
          w_out_val = 1'b1;
`ifdef LAB1_IMUL_SET_BIT_SCANNER_OVERLAP_EN
          w_in_rdy  = out_rdy && w_last;
`else
          w_in_rdy  = 1'b0;
`endif
        end
        default: begin
          w_out_val = 1'b0;
          w_in_rdy  = 1'b0;
        end
      endcase
    end
    w_in_go  = in_val && w_in_rdy;
    w_out_go = w_out_val && out_rdy;
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_residue_nxt   = r_residue;
    w_prev_pos_nxt  = r_prev_pos;
    w_zero_flag_nxt = r_zero_flag;
    case (r_state)
      IDLE: begin
        if (w_in_go) begin
          w_residue_nxt   = in_msg;
          w_prev_pos_nxt  = '0;
          w_zero_flag_nxt = (in_msg == '0);
          w_state_nxt     = EMIT;
        end
      end
      EMIT: begin
        if (w_out_go) begin
          w_residue_nxt  = w_residue_drop;
          w_prev_pos_nxt = w_low_pos;
          if (w_last) begin
            w_state_nxt = IDLE;
          end
        end
        // A new operand can only land here together with the final record.
        if (w_in_go) begin
          w_residue_nxt   = in_msg;
          w_prev_pos_nxt  = '0;
          w_zero_flag_nxt = (in_msg == '0);
          w_state_nxt     = EMIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_residue   <= '0;
      r_prev_pos  <= '0;
      r_zero_flag <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_residue   <= w_residue_nxt;
      r_prev_pos  <= w_prev_pos_nxt;
      r_zero_flag <= w_zero_flag_nxt;
    end
  end

  // Record fields, zeroed whenever no record is presented.
  always_comb begin
    in_rdy    = w_in_rdy;
    out_val   = w_out_val;
    out_pos   = '0;
    out_delta = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    if (w_out_val) begin
      out_pos   = w_low_pos;
      out_delta = w_low_pos - r_prev_pos;
      out_last  = w_last;
      out_empty = r_zero_flag;
    end
  end

endmodule

// File: tb/tb_lab1_imul_set_bit_scanner.sv
// Self-checking bench for lab1_imul_set_bit_scanner (p_nbits=32).
// Expected records come from a list model built straight from the operand bits.

module tb_lab1_imul_set_bit_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [4:0]  out_pos;
  logic [4:0]  out_delta;
  logic        out_last;
  logic        out_empty;

  int n_cmp = 0;
  int n_err = 0;

  int q_pos[$];
  int q_dlt[$];
  int q_last[$];
  int q_emp[$];

  always #5 clk = ~clk;

  lab1_imul_set_bit_scanner #(.p_nbits(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_pos   (out_pos),
    .out_delta (out_delta),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of set-bit positions in ascending order, with gaps.
  task automatic model(input logic [31:0] x);
    int prev;
    prev = 0;
    q_pos.delete(); q_dlt.delete(); q_last.delete(); q_emp.delete();
    if (x == 32'h0) begin
      q_pos.push_back(0); q_dlt.push_back(0); q_last.push_back(1); q_emp.push_back(1);
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (x[i]) begin
          q_pos.push_back(i); q_dlt.push_back(i - prev);
          q_last.push_back(0); q_emp.push_back(0);
          prev = i;
        end
      end
      q_last[q_last.size()-1] = 1;
    end
  endtask

  task automatic send(input logic [31:0] x);
    int t;
    t = 0;
    @(negedge clk);
    in_val = 1'b1; in_msg = x; out_rdy = 1'b0;
    #1;
    while (!in_rdy && t < 50) begin
      @(negedge clk); #1; t++;
    end
    chk("accept_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk); #1;
    in_val = 1'b0;
    in_msg = $urandom;
  endtask

  task automatic drain(input int n_take, input int stall_pct, input int stall_rec, input int stall_n);
    int k, stalls, cyc;
    k = 0; stalls = 0; cyc = 0;
    while (k < n_take && cyc < 2000) begin
      @(negedge clk);
      if (k == stall_rec && stalls < stall_n) begin
        out_rdy = 1'b0; stalls++;
      end else begin
        out_rdy = ($urandom_range(0, 99) >= 32'(stall_pct));
      end
      in_msg = $urandom;
      #1;
      chk("rec_val",   32'(out_val),   32'd1);
      chk("rec_pos",   32'(out_pos),   32'(q_pos[k]));
      chk("rec_delta", 32'(out_delta), 32'(q_dlt[k]));
      chk("rec_last",  32'(out_last),  32'(q_last[k]));
      chk("rec_empty", 32'(out_empty), 32'(q_emp[k]));
`ifndef LAB1_IMUL_SET_BIT_SCANNER_OVERLAP_EN
      chk("rec_in_rdy", 32'(in_rdy), 32'd0);
`endif
      if (out_rdy) k++;
      cyc++;
    end
    chk("drain_count", 32'(k), 32'(n_take));
  endtask

  task automatic idle_check();
    @(negedge clk);
    out_rdy = 1'b1;
    #1;
    chk("idle_val", 32'(out_val), 32'd0);
    chk("idle_rdy", 32'(in_rdy), 32'd1);
  endtask

  initial begin
    int e_val[6];
    int e_pos[6];
    int e_iv[6];
    int e_rdy[6];
    int ov_n;
    logic [31:0] x;

    reset = 1'b1; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_val", 32'(out_val), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("post_rst_fields", {out_val, out_pos, out_delta, out_last, out_empty}, 32'd0);

    // Zero operand: single marker record.
    model(32'h0); send(32'h0); drain(q_pos.size(), 0, -1, 0); idle_check();
    // Bits at both ends.
    model(32'h8000_0001); send(32'h8000_0001); drain(q_pos.size(), 0, -1, 0); idle_check();
    // Stall 3 cycles on the second record.
    model(32'h0000_00B4); send(32'h0000_00B4); drain(q_pos.size(), 0, 1, 3); idle_check();
    // All ones at full rate.
    model(32'hFFFF_FFFF); send(32'hFFFF_FFFF); drain(q_pos.size(), 0, -1, 0); idle_check();

    // Reset after the second record discards the rest.
    model(32'h0000_00B4); send(32'h0000_00B4); drain(2, 0, -1, 0);
    @(negedge clk);
    reset = 1'b1; out_rdy = 1'b1;
    #1;
    chk("midrst_val", 32'(out_val), 32'd0);
    chk("midrst_rdy", 32'(in_rdy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after_midrst_val", 32'(out_val), 32'd0);
    chk("after_midrst_rdy", 32'(in_rdy), 32'd1);
    chk("after_midrst_fields", {out_pos, out_delta, out_last, out_empty}, 32'd0);
    model(32'h10); send(32'h10); drain(q_pos.size(), 0, -1, 0); idle_check();

    // Back-to-back operands 0x3 then 0x5 with in_val held high.
`ifdef LAB1_IMUL_SET_BIT_SCANNER_OVERLAP_EN
    ov_n  = 5;
    e_val = '{0, 1, 1, 1, 1, 0};
    e_pos = '{0, 0, 1, 0, 2, 0};
    e_iv  = '{1, 1, 1, 0, 0, 0};
    e_rdy = '{1, 0, 1, 0, 1, 0};
`else
    ov_n  = 6;
    e_val = '{0, 1, 1, 0, 1, 1};
    e_pos = '{0, 0, 1, 0, 0, 2};
    e_iv  = '{1, 1, 1, 1, 0, 0};
    e_rdy = '{1, 0, 0, 1, 0, 0};
`endif
    for (int c = 0; c < ov_n; c++) begin
      @(negedge clk);
      in_val = e_iv[c][0];
      in_msg = (c == 0) ? 32'h3 : 32'h5;
      out_rdy = 1'b1;
      #1;
      chk("b2b_val", 32'(out_val), 32'(e_val[c]));
      chk("b2b_rdy", 32'(in_rdy), 32'(e_rdy[c]));
      if (e_val[c] != 0) chk("b2b_pos", 32'(out_pos), 32'(e_pos[c]));
    end
    @(negedge clk);
    in_val = 1'b0;
    #1;
    chk("b2b_end_val", 32'(out_val), 32'd0);

    // Randomized operands of varied density under random backpressure.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       x = $urandom;
        1:       x = $urandom & $urandom & $urandom;
        2:       x = 32'h1 << $urandom_range(0, 31);
        3:       x = $urandom | $urandom;
        default: x = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom);
      endcase
      model(x); send(x); drain(q_pos.size(), 30, -1, 0); idle_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lab1_imul_set_bit_scanner.md
# lab1_imul_set_bit_scanner

Sequential, parametrised set-bit scanner for the iterative multiplier datapath. It accepts one operand over a val/rdy handshake and emits every set bit, LSB first, one per cycle over a second val/rdy handshake. Each output carries the absolute bit position and the shift distance from the previously emitted set bit, so the multiplier skips runs of zeros of any length in a single step. It is the multi-cycle, width-generic successor to the single-shot trailing-zero shift encoder.

## Interface

- p_nbits, 32, operand width; must be ≥ 2. Define p_pbits = $clog2(p_nbits).
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_val  input  1  operand valid
- in_rdy  output  1  scanner can accept an operand
- in_msg  input  p_nbits  operand to scan
- out_val  output  1  output record valid
- out_rdy  input  1  consumer accepts the record
- out_pos  output  p_pbits  index of the current lowest set bit
- out_delta  output  p_pbits  out_pos minus the previously emitted position, or out_pos for the first record
- out_last  output  1  this is the final record for the operand
- out_empty  output  1  operand was zero; marker record only

## Operation

- State registers: state ∈ {IDLE, EMIT}, residue[p_nbits], prev_pos[p_pbits], zero_flag.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val&&in_rdy: residue←in_msg, prev_pos←0, zero_flag←(in_msg==0), state←EMIT.
- EMIT: out_val=1; in_rdy=0 unless overlap is enabled (see Configuration). Record fields are combinational from registers:
  - out_pos = index of the lowest set bit of residue; 0 if residue==0.
  - out_delta = out_pos − prev_pos, unsigned and never negative; for the first record it equals out_pos because prev_pos=0.
  - out_last = 1 when residue has at most one bit set.
  - out_empty = zero_flag.
- On out_val&&out_rdy in EMIT:
  - clear bit out_pos of residue; prev_pos←out_pos.
  - if out_last: state←IDLE.
- Zero operand: exactly one record is emitted, with pos=0, delta=0, last=1, empty=1.
- Backpressure: while out_val=1 and out_rdy=0, all out_* fields hold stable and no state changes.
- Ordering: records are strictly ascending in position; exactly popcount(in_msg) records are emitted, or 1 for a zero operand.

## Timing

- Reset: while reset=1, in_rdy=0 and out_val=0. The edge with reset=1 sets state←IDLE and clears residue, prev_pos and zero_flag. In the first cycle after deassertion, in_rdy=1 and all out_* fields are 0.
- Reset mid-operation: the in-flight operand is discarded with no further records; out_val=0 in the cycle after the reset edge.
- Latency: the first record is valid in the cycle after the input handshake.
- Throughput: with out_rdy held at 1, one record per cycle.
- Operand turnaround without overlap: popcount+1 cycles (the IDLE accept cycle plus one cycle per record).
- in_msg is sampled only on the accept edge. Changes to in_msg at any other time have no effect.

## Configuration

- Macro LAB1_IMUL_SET_BIT_SCANNER_OVERLAP_EN enables back-to-back operands.
  - Defined: in EMIT, in_rdy = out_rdy && out_last. When both handshakes fire in the same cycle, the new operand is loaded and state stays in EMIT. This removes the idle bubble, and turnaround becomes popcount cycles.
  - Undefined: in_rdy=1 only in IDLE, and one bubble cycle separates operands.

## Test plan

- p_nbits=32, in_msg=0x00000000 → one record: pos=0, delta=0, last=1, empty=1. in_rdy returns to 1 on the next cycle.
- in_msg=0x80000001 → (pos=0, delta=0, last=0), then (pos=31, delta=31, last=1). empty=0 on both records.
- in_msg=0x000000B4 with out_rdy low for 3 cycles during the 2nd record → positions 2, 4, 5, 7 and deltas 2, 2, 1, 2; last=1 only on the 4th record. The 2nd record is held unchanged while stalled.
- in_msg=0xFFFFFFFF with out_rdy=1 → 32 consecutive valid cycles at positions 0..31. delta=0 on the first record and 1 on all others; last=1 only at pos=31.
- Reset pulsed after the 2nd record of 0x000000B4 → out_val=0 on the following cycle. After reset drops, in_msg=0x10 produces a single record pos=4, delta=4, last=1.
- 0x3 followed immediately by 0x5, in_val held high → with the macro defined, 0x5 is accepted on the same edge as the last record of 0x3, giving pos 0, 1, 0, 2 on 4 consecutive cycles. Without the macro, one out_val=0 cycle appears between the two operands.
